dds_param_scheduler: RTL

- Timed parameter scheduler feeding the DDS phase MAC stage directly upstream.
- Owns the free-running 48-bit timestamp and buffers timed commands (freq, phase, sync) in a small FIFO.
- Applies each command on the exact cycle the timestamp reaches the command time.
- Drives timestamp, timeoffset, freq and phase, held stable between updates, so the MAC computes phase_acc = (timestamp - timeoffset) * freq + phase.

---
 rtl/dds_pkg.sv | 29 ++
 rtl/dds_cmd_fifo.sv | 67 ++++++
 rtl/dds_param_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dds_pkg
//  Description : Shared widths, command record and FSM encoding for the DDS
//                timed parameter scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

    localparam int TS_W    = 48;
    localparam int FREQ_W  = 48;
    localparam int PHASE_W = 14;

    // 'time' is a reserved word, so the apply timestamp field is named ts
    typedef struct packed {
        logic [TS_W-1:0]    ts;
        logic [FREQ_W-1:0]  freq;
        logic [PHASE_W-1:0] phase;
        logic               sync;
    } dds_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } dds_state_e;

endpackage
`default_nettype wire

// File: rtl/dds_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dds_cmd_fifo
//  Description : Synchronous show-ahead FIFO of timed DDS commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_cmd_fifo
    import dds_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  dds_cmd_t         i_data,
    input  logic             i_pop,
    output dds_cmd_t         o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int c_AW = CNT_W - 1;

    dds_cmd_t         r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dds_param_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dds_param_scheduler
//  Description : Free-running timestamp plus timed freq/phase/sync command
//                scheduler feeding the DDS phase MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_param_scheduler
    import dds_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [TS_W-1:0]    s_time,
    input  logic [FREQ_W-1:0]  s_freq,
    input  logic [PHASE_W-1:0] s_phase,
    input  logic               s_sync,
    input  logic               ts_load,
    input  logic [TS_W-1:0]    ts_load_value,
    input  logic               clear_late,
    output logic [TS_W-1:0]    timestamp,
    output logic [TS_W-1:0]    timeoffset,
    output logic [FREQ_W-1:0]  freq,
    output logic [PHASE_W-1:0] phase,
    output logic               update_pulse,
    output logic               late_flag,
    output logic [CNT_W-1:0]   fifo_count
);

    dds_state_e         r_state;
    dds_state_e         w_state_nxt;
    dds_cmd_t           r_hold;
    dds_cmd_t           w_fifo_head;
    dds_cmd_t           w_s_cmd;
    logic [TS_W-1:0]    r_ts;
    logic [TS_W-1:0]    r_toff;
    logic [FREQ_W-1:0]  r_freq;
    logic [PHASE_W-1:0] r_phase;
    logic               r_late;
    logic [TS_W-1:0]    w_ts_nxt;
    logic [TS_W-1:0]    w_diff;
    logic               w_on_time;
    logic               w_late;
    logic               w_due;
    logic               w_fire;
    logic               w_pop;
    logic               w_push;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    assign s_ready = resetn && !w_fifo_full;
    assign w_push  = s_valid && s_ready;
    assign w_s_cmd = '{ts: s_time, freq: s_freq, phase: s_phase, sync: s_sync};

    dds_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (w_s_cmd),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    // Compare against the value the timestamp takes on the coming edge so the
    // new parameters land together with the matching timestamp.
    assign w_ts_nxt  = ts_load ? ts_load_value : r_ts + TS_W'(1);
    assign w_diff    = r_hold.ts - w_ts_nxt;
    assign w_on_time = (w_diff == '0);
    assign w_late    = w_diff[TS_W-1];
    assign w_due     = w_on_time || w_late;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_fifo_empty) w_state_nxt = ARMED;
            ARMED:   if (w_due) w_state_nxt = APPLY;
            APPLY:   w_state_nxt = w_fifo_empty ? IDLE : ARMED;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_pop        = 1'b0;
        w_fire       = 1'b0;
        update_pulse = 1'b0;
        case (r_state)
            IDLE:  w_pop = !w_fifo_empty;
            ARMED: w_fire = w_due;
            APPLY: begin
                update_pulse = 1'b1;
                w_pop        = !w_fifo_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ts    <= '0;
            r_hold  <= '0;
            r_toff  <= '0;
            r_freq  <= '0;
            r_phase <= '0;
            r_late  <= 1'b0;
        end else begin
            r_ts <= w_ts_nxt;
            if (w_pop) begin
                r_hold <= w_fifo_head;
            end
            if (w_fire) begin
                r_freq  <= r_hold.freq;
                r_phase <= r_hold.phase;
                if (r_hold.sync) begin
                    r_toff <= r_hold.ts;
                end
            end
            if (w_fire && w_late) begin
                r_late <= 1'b1;
            end else if (clear_late) begin
                r_late <= 1'b0;
            end
        end
    end

    assign timestamp  = r_ts;
    assign timeoffset = r_toff;
    assign freq       = r_freq;
    assign phase      = r_phase;
    assign late_flag  = r_late;

endmodule
`default_nettype wire
